// File: rtl/fifo_pkt_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fifo_pkt_pkg                                           |
// | Description : Shared types and constants for the 80-bit packet FIFO  |
// |               packer/unpacker pair and their testbenches.            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package fifo_pkt_pkg;

  localparam int PKT_BYTES = 10;
  localparam int BYTE_W    = 8;
  localparam int PKT_W     = PKT_BYTES * BYTE_W;

  typedef logic [PKT_W-1:0]  pkt_t;
  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage : fifo_pkt_pkg
`default_nettype wire

// File: rtl/fifo_pkt_unpacker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fifo_pkt_unpacker                                      |
// | Description : Pops one packet at a time from the packet FIFO read    |
// |               port and streams it out byte 0 first over a            |
// |               valid/ready handshake, sustaining one byte per cycle.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module fifo_pkt_unpacker #(
  parameter int PKT_BYTES = 10,
  parameter int CNT_W     = 16
) (
  input  logic                   rclk,
  input  logic                   rst,
  input  logic [PKT_BYTES*8-1:0] rdata,
  input  logic                   rempty,
  output logic                   rinc,
  output logic [7:0]             m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_first,
  output logic                   m_last,
  output logic                   busy,
  output logic [CNT_W-1:0]       pkt_count
);

  import fifo_pkt_pkg::*;

  localparam int c_BUF_W = PKT_BYTES * 8;
  localparam int c_IDX_W = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(PKT_BYTES - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_IDX_W-1:0]   r_idx;
  logic [c_IDX_W-1:0]   w_idx_nxt;
  logic [c_BUF_W-1:0]   r_buf;
  logic [c_BUF_W-1:0]   w_buf_nxt;
  logic [c_BUF_W-1:0]   w_shift;
  logic [CNT_W-1:0]     r_count;
  logic [CNT_W-1:0]     w_count_nxt;
  logic                 w_fire;
  logic                 w_is_last;
  logic                 w_load;

  // State, byte index, packet buffer and delivered-packet counter registers
  always_ff @(posedge rclk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_buf   <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_buf   <= w_buf_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Output decode, FIFO pop decision and next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_buf_nxt   = r_buf;
    w_count_nxt = r_count;

    // Byte select by shifting the buffer down by index*8 bits.
    w_shift   = r_buf >> {r_idx, 3'b000};
    w_is_last = (r_idx == c_LAST_IDX);

    m_valid = (r_state == SEND);
    busy    = (r_state == SEND);
    m_data  = m_valid ? w_shift[BYTE_W-1:0] : '0;
    m_first = m_valid && (r_idx == '0);
    m_last  = m_valid && w_is_last;
    w_fire  = m_valid && m_ready;

    // A new packet is taken either from idle or on the same edge the last
    // byte of the current one is accepted, so back-to-back packets stream
    // without a bubble. rst gates the pop so a held reset never drains the
    // FIFO.
    w_load = !rst && !rempty &&
             ((r_state == IDLE) || (r_state == SEND && w_fire && w_is_last));
    rinc   = w_load;

    if (w_fire && w_is_last) begin
      w_count_nxt = r_count + CNT_W'(1);
    end

    if (w_load) begin
      w_state_nxt = SEND;
      w_idx_nxt   = '0;
      w_buf_nxt   = rdata;
    end else if (w_fire) begin
      if (w_is_last) begin
        w_state_nxt = IDLE;
      end else begin
        w_idx_nxt = r_idx + c_IDX_W'(1);
      end
    end

    pkt_count = r_count;
  end

endmodule : fifo_pkt_unpacker
`default_nettype wire
